// File: rtl/asl_bin_pkg.sv
// Shared types and constants for the bin frame sequencer and its scaler.
//   seq_state_t : sequencer FSM states
//   NUM_BIN_*   : bin grid geometry (32 x 32)
//   BIN_SUM_W   : width of one bank sum entry
//   PIX_W       : width of one normalised output channel
//   sat8()      : clamp a scaled value to the pixel range
package asl_bin_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } seq_state_t;

  localparam int NUM_BIN_COLS       = 32;
  localparam int NUM_BIN_ROWS       = 32;
  localparam int BIN_SUM_W          = 16;
  localparam int PIX_W              = 8;
  localparam int DEFAULT_SCALE_MULT = 2396;

  // 16-bit sum times 12-bit multiplier gives a 28-bit product; the top
  // 12 bits are the scaled value before saturation.
  localparam int MULT_W   = 12;
  localparam int PROD_W   = BIN_SUM_W + MULT_W;
  localparam int SCALED_W = PROD_W - BIN_SUM_W;

  function automatic logic [PIX_W-1:0] sat8(input logic [SCALED_W-1:0] v);
    return (v > SCALED_W'((1 << PIX_W) - 1)) ? '1 : v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/bin_scaler.sv
// Combinational normaliser: one bank sum -> one saturated 8-bit channel.
//   pix = sat8((sum * SCALE_MULT) >> 16)
// Ports:
//   sum : 16-bit bin sum
//   pix : 8-bit normalised pixel channel
module bin_scaler
  import asl_bin_pkg::*;
#(
  parameter int SCALE_MULT = DEFAULT_SCALE_MULT
) (
  input  logic [BIN_SUM_W-1:0] sum,
  output logic [PIX_W-1:0]     pix
);

  localparam logic [MULT_W-1:0] MULT = MULT_W'(SCALE_MULT);

  logic [PROD_W-1:0]   prod;
  logic [SCALED_W-1:0] scaled;

  // NOTE: pure continuous assignments; every output is fully defined on every
  // evaluation, so no storage can be inferred here.
  assign prod   = PROD_W'(sum) * PROD_W'(MULT);
  assign scaled = SCALED_W'(prod >> BIN_SUM_W);
  assign pix    = sat8(scaled);

endmodule

// File: rtl/bin_frame_sequencer.sv
// Frames one pixel_binner capture per request and streams each completed
// 32-bin row as normalised RGB pixels over a valid/ready interface.
// Ports:
//   clk, resetn             : clock, async active-low reset
//   frame_req, abort        : frame control (frame_req only seen when idle)
//   frame_busy/done/err     : status (done is a pulse, err is sticky)
//   start_en                : enables the binner
//   pxl_idle_i, row_i       : binner idle flag and completed-row counter
//   r/g/b_bank              : binner double-buffered sums [bank][col]
//   pix_valid, pix_ready    : output stream handshake
//   pix_r/g/b, pix_row/col  : output pixel and its bin coordinates
module bin_frame_sequencer
  import asl_bin_pkg::*;
#(
  parameter int          SCALE_MULT     = DEFAULT_SCALE_MULT,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd0
) (
  input  logic clk,
  input  logic resetn,
  input  logic frame_req,
  input  logic abort,
  output logic frame_busy,
  output logic frame_done,
  output logic frame_err,
  output logic start_en,
  input  logic pxl_idle_i,
  input  logic [5:0] row_i,
  input  logic [1:0][NUM_BIN_COLS-1:0][BIN_SUM_W-1:0] r_bank,
  input  logic [1:0][NUM_BIN_COLS-1:0][BIN_SUM_W-1:0] g_bank,
  input  logic [1:0][NUM_BIN_COLS-1:0][BIN_SUM_W-1:0] b_bank,
  output logic pix_valid,
  input  logic pix_ready,
  output logic [PIX_W-1:0] pix_r,
  output logic [PIX_W-1:0] pix_g,
  output logic [PIX_W-1:0] pix_b,
  output logic [4:0] pix_row,
  output logic [4:0] pix_col
);

  localparam logic [4:0] LAST_COL = 5'(NUM_BIN_COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(NUM_BIN_ROWS - 1);

  seq_state_t  state;
  logic [5:0]  row_q;
  logic [4:0]  row_k;        // bin row being drained
  logic        bank_q;       // bank holding row_k
  logic [4:0]  col_cnt;      // next column to load
  logic        last_loaded;  // last column is in the output register
  logic [23:0] wdog;

  logic             row_event;
  logic [4:0]       new_k;
  logic             accept;
  logic             load_en;
  logic             wd_counting;
  logic             wd_expired;
  logic [23:0]      wdog_step;
  logic [PIX_W-1:0] r_pix, g_pix, b_pix;

  assign row_event   = (row_i != row_q);
  // row_i counts completed rows, so the row just finished is one behind.
  assign new_k       = row_i[4:0] - 5'd1;
  assign accept      = pix_valid & pix_ready;
  assign load_en     = ~pix_valid | pix_ready;
  assign wd_counting = (state == S_ARM) || (state == S_RUN) || (state == S_FINISH);
  assign wd_expired  = (TIMEOUT_CYCLES != 24'd0) && wd_counting && (wdog == TIMEOUT_CYCLES);
  assign wdog_step   = row_event ? 24'd0 : wdog + 24'd1;

  bin_scaler #(.SCALE_MULT(SCALE_MULT)) u_scale_r (.sum(r_bank[bank_q][col_cnt]), .pix(r_pix));
  bin_scaler #(.SCALE_MULT(SCALE_MULT)) u_scale_g (.sum(g_bank[bank_q][col_cnt]), .pix(g_pix));
  bin_scaler #(.SCALE_MULT(SCALE_MULT)) u_scale_b (.sum(b_bank[bank_q][col_cnt]), .pix(b_pix));

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      row_q       <= '0;
      row_k       <= '0;
      bank_q      <= 1'b0;
      col_cnt     <= '0;
      last_loaded <= 1'b0;
      wdog        <= '0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      start_en    <= 1'b0;
      pix_valid   <= 1'b0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      pix_row     <= '0;
      pix_col     <= '0;
    end else begin
      frame_done <= 1'b0;
      // Tracked in every state so entering S_RUN never sees a stale row.
      row_q      <= row_i;

      if (state != S_IDLE && abort) begin
        // Abort outranks any simultaneous row event or handshake.
        start_en    <= 1'b0;
        pix_valid   <= 1'b0;
        frame_err   <= 1'b1;
        last_loaded <= 1'b0;
        wdog        <= '0;
        state       <= S_FINISH;
      end else if (wd_expired) begin
        frame_err  <= 1'b1;
        start_en   <= 1'b0;
        frame_busy <= 1'b0;
        wdog       <= '0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (frame_req) begin
              start_en   <= 1'b1;
              frame_err  <= 1'b0;
              frame_busy <= 1'b1;
              wdog       <= '0;
              state      <= S_ARM;
            end
          end

          S_ARM: begin
            if (!pxl_idle_i) begin
              wdog  <= '0;
              state <= S_RUN;
            end else begin
              wdog <= wdog_step;
            end
          end

          S_RUN: begin
            if (row_event) begin
              row_k       <= new_k;
              bank_q      <= new_k[0];
              col_cnt     <= '0;
              last_loaded <= 1'b0;
              wdog        <= '0;
              state       <= S_DRAIN;
            end else begin
              wdog <= wdog + 24'd1;
            end
          end

          S_DRAIN: begin
            wdog <= '0;
            if (row_event) begin
              // The binner is about to reuse the bank we were reading, so the
              // rest of this row is lost; only a cleanly finished row is not
              // an overrun. The beat on the output still completes normally.
              if (!(last_loaded && accept)) frame_err <= 1'b1;
              row_k       <= new_k;
              bank_q      <= new_k[0];
              col_cnt     <= '0;
              last_loaded <= 1'b0;
              if (accept) pix_valid <= 1'b0;
            end else if (last_loaded) begin
              if (accept) begin
                pix_valid   <= 1'b0;
                last_loaded <= 1'b0;
                if (row_k == LAST_ROW) begin
                  start_en <= 1'b0;
                  state    <= S_FINISH;
                end else begin
                  state <= S_RUN;
                end
              end
            end else if (load_en) begin
              pix_valid <= 1'b1;
              pix_r     <= r_pix;
              pix_g     <= g_pix;
              pix_b     <= b_pix;
              pix_row   <= row_k;
              pix_col   <= col_cnt;
              col_cnt   <= col_cnt + 5'd1;
              if (col_cnt == LAST_COL) last_loaded <= 1'b1;
            end
          end

          S_FINISH: begin
            start_en <= 1'b0;
            if (pxl_idle_i) begin
              if (!frame_err) frame_done <= 1'b1;
              frame_busy <= 1'b0;
              wdog       <= '0;
              state      <= S_IDLE;
            end else begin
              wdog <= wdog_step;
            end
          end

          default: begin
            frame_busy <= 1'b0;
            start_en   <= 1'b0;
            pix_valid  <= 1'b0;
            state      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bin_frame_sequencer.sv
// Scoreboard bench for bin_frame_sequencer: the stimulus pushes expected
// beats when it advances the binner row counter; a negedge monitor pops and
// compares every accepted beat. A second instance covers the watchdog.
module tb_bin_frame_sequencer;
  import asl_bin_pkg::*;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [4:0] row;
    logic [4:0] col;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       frame_req, abort, pxl_idle, ready_lvl, bp_mode, pix_ready;
  logic [5:0] row;
  logic [1:0][31:0][15:0] r_bank, g_bank, b_bank;
  logic       frame_busy, frame_done, frame_err, start_en, pix_valid;
  logic [7:0] pix_r, pix_g, pix_b;
  logic [4:0] pix_row, pix_col;

  logic       wd_frame_req, wd_abort, wd_idle, wd_ready;
  logic [5:0] wd_row;
  logic       wd_busy, wd_done, wd_err, wd_start_en, wd_pix_valid;
  logic [7:0] wd_pix_r, wd_pix_g, wd_pix_b;
  logic [4:0] wd_pix_row, wd_pix_col;

  bin_frame_sequencer dut (
    .clk(clk), .resetn(resetn), .frame_req(frame_req), .abort(abort),
    .frame_busy(frame_busy), .frame_done(frame_done), .frame_err(frame_err),
    .start_en(start_en), .pxl_idle_i(pxl_idle), .row_i(row),
    .r_bank(r_bank), .g_bank(g_bank), .b_bank(b_bank),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_row(pix_row), .pix_col(pix_col)
  );

  bin_frame_sequencer #(.TIMEOUT_CYCLES(24'd100)) dut_wd (
    .clk(clk), .resetn(resetn), .frame_req(wd_frame_req), .abort(wd_abort),
    .frame_busy(wd_busy), .frame_done(wd_done), .frame_err(wd_err),
    .start_en(wd_start_en), .pxl_idle_i(wd_idle), .row_i(wd_row),
    .r_bank(r_bank), .g_bank(g_bank), .b_bank(b_bank),
    .pix_valid(wd_pix_valid), .pix_ready(wd_ready),
    .pix_r(wd_pix_r), .pix_g(wd_pix_g), .pix_b(wd_pix_b),
    .pix_row(wd_pix_row), .pix_col(wd_pix_col)
  );

  // Backpressure pattern: ready on one cycle out of three.
  logic [1:0] ph;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) ph <= 2'd0;
    else         ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
  end
  assign pix_ready = bp_mode ? (ph == 2'd0) : ready_lvl;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed scaling pairs: 6975->255, 3487->127, 0->0, 65535->255, 225->8.
  logic [15:0] sum_tbl [5] = '{16'd6975, 16'd3487, 16'd0, 16'd65535, 16'd225};
  logic [7:0]  pix_tbl [5] = '{8'd255, 8'd127, 8'd0, 8'd255, 8'd8};
  bit all_max;

  task automatic fill_banks(input bit max_only);
    all_max = max_only;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 32; c++) begin
        r_bank[b][c] = max_only ? 16'd6975 : sum_tbl[(c + 3*b) % 5];
        g_bank[b][c] = max_only ? 16'd6975 : sum_tbl[(c + 1 + 3*b) % 5];
        b_bank[b][c] = max_only ? 16'd6975 : sum_tbl[(c + 2 + 3*b) % 5];
      end
    end
  endtask

  function automatic beat_t exp_beat(input logic [4:0] k, input logic [4:0] c);
    beat_t e;
    int    base;
    base  = int'(c) + 3 * int'(k[0]);
    e.r   = all_max ? 8'd255 : pix_tbl[base % 5];
    e.g   = all_max ? 8'd255 : pix_tbl[(base + 1) % 5];
    e.b   = all_max ? 8'd255 : pix_tbl[(base + 2) % 5];
    e.row = k;
    e.col = c;
    return e;
  endfunction

  beat_t exp_q[$];

  // ---------------- monitor ----------------
  beat_t cur, held, e;
  bit    stalled = 1'b0;
  int    last_acc = 0;
  int    beats = 0;
  int    done_cnt = 0;

  always @(negedge clk) begin
    if (resetn) begin
      if (frame_done) done_cnt++;
      if (stalled) check("valid_held", 32'(pix_valid), 32'd1);
      if (pix_valid) begin
        cur = {pix_r, pix_g, pix_b, pix_row, pix_col};
        if (stalled) check("hold_stable", 32'(cur), 32'(held));
        if (pix_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: actual row %0d col %0d required none", pix_row, pix_col);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'(cur), 32'(e));
          end
          if (bp_mode && pix_col != 5'd0) check("bp_gap", 32'(cyc - last_acc), 32'd3);
          last_acc = cyc;
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = cur;
        end
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_req = 1'b1;
    wait_cycles(1);
    frame_req = 1'b0;
    check("start_en_rise", 32'(start_en), 32'd1);
    check("busy_rise", 32'(frame_busy), 32'd1);
    check("err_cleared", 32'(frame_err), 32'd0);
    wait_cycles(2);
    pxl_idle = 1'b0;
    wait_cycles(2);
  endtask

  // Binner finished row n-1: expect columns 0..c_last of it.
  task automatic set_row(input int n, input int c_last);
    row = 6'(n);
    for (int c = 0; c <= c_last; c++) exp_q.push_back(exp_beat(5'(n - 1), 5'(c)));
  endtask

  task automatic end_frame(input int exp_done, input bit exp_err, input int d0);
    for (int i = 0; i < 300 && start_en; i++) wait_cycles(1);
    check("finish_start_en_low", 32'(start_en), 32'd0);
    wait_cycles(3);
    pxl_idle = 1'b1;
    row      = 6'd0;
    for (int i = 0; i < 20 && frame_busy; i++) wait_cycles(1);
    check("back_to_idle", 32'(frame_busy), 32'd0);
    wait_cycles(2);
    check("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    check("frame_err_end", 32'(frame_err), 32'(exp_err));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0, b0, n;
    resetn = 1'b0; frame_req = 1'b0; abort = 1'b0; pxl_idle = 1'b1;
    ready_lvl = 1'b1; bp_mode = 1'b0; row = 6'd0;
    wd_frame_req = 1'b0; wd_abort = 1'b0; wd_idle = 1'b1; wd_ready = 1'b1; wd_row = 6'd0;
    fill_banks(1'b1);

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_start_en", 32'(start_en), 32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_pix", 32'({pix_r, pix_g, pix_b, pix_row, pix_col}), 32'd0);
    check("rst_wd_start_en", 32'(wd_start_en), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_cycles(2);

    // Frame A: full frame, all sums 6975, no backpressure.
    d0 = done_cnt; b0 = beats;
    start_frame();
    for (int r = 1; r <= 32; r++) begin
      set_row(r, 31);
      wait_cycles(40);
    end
    end_frame(1, 1'b0, d0);
    check("frameA_beats", 32'(beats - b0), 32'd1024);

    // Frame B: scaling table, alternating banks, 1-of-3 backpressure.
    fill_banks(1'b0);
    bp_mode = 1'b1;
    d0 = done_cnt; b0 = beats;
    start_frame();
    for (int r = 1; r <= 32; r++) begin
      set_row(r, 31);
      wait_cycles(120);
    end
    end_frame(1, 1'b0, d0);
    check("frameB_beats", 32'(beats - b0), 32'd1024);
    bp_mode = 1'b0;

    // Frame C: overrun while stalled on row 4 col 0, new row 5 drains from col 0.
    d0 = done_cnt;
    start_frame();
    n = 1;
    while (n <= 32) begin
      if (n == 5) begin
        ready_lvl = 1'b0;
        set_row(5, 0);
        wait_cycles(5);
        set_row(6, 31);
        wait_cycles(2);
        check("overrun_err", 32'(frame_err), 32'd1);
        check("overrun_stall_valid", 32'(pix_valid), 32'd1);
        ready_lvl = 1'b1;
        wait_cycles(40);
        n = 7;
      end else begin
        set_row(n, 31);
        wait_cycles(40);
        n++;
      end
    end
    end_frame(0, 1'b1, d0);

    // Frame D: abort when col 10 of row 0 is on the output.
    d0 = done_cnt;
    start_frame();
    set_row(1, 10);
    n = 0;
    while (n < 50 && !(pix_valid && pix_col == 5'd10)) begin
      @(negedge clk);
      n++;
    end
    check("abort_col10_seen", 32'(pix_col), 32'd10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_start_en", 32'(start_en), 32'd0);
    check("abort_valid", 32'(pix_valid), 32'd0);
    check("abort_err", 32'(frame_err), 32'd1);
    check("abort_busy", 32'(frame_busy), 32'd1);
    @(posedge clk); #1;
    end_frame(0, 1'b1, d0);

    // Watchdog instance: binner never leaves idle while armed.
    wd_frame_req = 1'b1;
    @(posedge clk); #1;
    wd_frame_req = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!wd_start_en) break;
      n++;
    end
    check("wd_cycles_armed", 32'(n), 32'd101);
    check("wd_err", 32'(wd_err), 32'd1);
    check("wd_idle_state", 32'(wd_busy), 32'd0);
    @(posedge clk); #1;
    wd_frame_req = 1'b1;
    @(posedge clk); #1;
    wd_frame_req = 1'b0;
    check("wd_err_cleared", 32'(wd_err), 32'd0);
    check("wd_restart", 32'(wd_start_en), 32'd1);
    wait_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
